hero_write_gather: RTL and testbench

// - Packs a narrow hero-write beat stream (cycle type IDLE/VALID/DONE + data) into wide multi-lane words.
// - Sits between a hero-bus producer and a wide consumer.
// - Successor to the fixed 2-entry item-array type: lane count, lane width and output buffering are parameters.
// - Adds partial-word flush on DONE, a lane mask and a buffered valid/ready output.

---
 rtl/hero_write_gather_if.sv | 44 ++++
 rtl/hero_write_gather.sv | 152 +++++++++++++++
 tb/tb_hero_write_gather.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hero_write_gather_if.sv
// Hero-write gather stream bundle: narrow beat input side and wide packed-word output side.
// Macro HERO_GATHER_PARITY_EN adds the per-lane out_parity signal.
interface hero_write_gather_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4
);
  localparam int CNT_W = $clog2(NUM_LANES + 1);

  logic [1:0]                  in_cycle_type;
  logic [DATA_W-1:0]           in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_LANES*DATA_W-1:0] out_data;
  logic [NUM_LANES-1:0]        out_lane_mask;
  logic [CNT_W-1:0]            out_count;
  logic                        out_last;
  logic                        err_reserved;
`ifdef HERO_GATHER_PARITY_EN
  logic [NUM_LANES-1:0]        out_parity;

  modport master (
    output in_cycle_type, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane_mask, out_count, out_last,
           err_reserved, out_parity
  );
  modport slave (
    input  in_cycle_type, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane_mask, out_count, out_last,
           err_reserved, out_parity
  );
`else
  modport master (
    output in_cycle_type, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane_mask, out_count, out_last,
           err_reserved
  );
  modport slave (
    input  in_cycle_type, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane_mask, out_count, out_last,
           err_reserved
  );
`endif
endinterface

// File: rtl/hero_write_gather.sv
// Packs hero-write beats into NUM_LANES-wide words, flushing partial words on DONE, into an OUT_DEPTH queue.
// Optional feature macro: HERO_GATHER_PARITY_EN (per-lane even parity stored with each word).
//
// state      | meaning
// ST_EMPTY   | no beats collected, next beat lands in lane 0
// ST_PARTIAL | 0 < idx < NUM_LANES beats collected in the fill buffer
module hero_write_gather #(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4,
  parameter int OUT_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  hero_write_gather_if.slave bus
);
  localparam int WORD_W = NUM_LANES * DATA_W;
  localparam int IDX_W  = $clog2(NUM_LANES);
  localparam int CNT_W  = $clog2(NUM_LANES + 1);
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCC_W  = $clog2(OUT_DEPTH + 1);

  localparam logic [0:0] ST_EMPTY   = 1'b0;
  localparam logic [0:0] ST_PARTIAL = 1'b1;

  localparam logic [1:0] CT_VALID    = 2'd1;
  localparam logic [1:0] CT_DONE     = 2'd2;
  localparam logic [1:0] CT_RESERVED = 2'd3;

  logic [0:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] fill_buf;
  logic              err_reserved;

  logic [WORD_W-1:0]    q_data  [OUT_DEPTH];
  logic [NUM_LANES-1:0] q_mask  [OUT_DEPTH];
  logic [CNT_W-1:0]     q_count [OUT_DEPTH];
  logic                 q_last  [OUT_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [OCC_W-1:0]     occ;

  logic                 is_valid;
  logic                 is_done;
  logic                 is_reserved;
  logic                 head_valid;
  logic                 queue_full;
  logic                 pop;
  logic                 in_ready;
  logic                 accept;
  logic                 last_lane;
  logic                 push;
  logic [WORD_W-1:0]    word_next;
  logic [NUM_LANES-1:0] mask_next;
  logic [CNT_W-1:0]     count_next;

  assign is_valid    = (bus.in_cycle_type == CT_VALID);
  assign is_done     = (bus.in_cycle_type == CT_DONE);
  assign is_reserved = (bus.in_cycle_type == CT_RESERVED);

  assign head_valid = (occ != '0);
  assign queue_full = (occ == OCC_W'(OUT_DEPTH));
  assign pop        = head_valid && bus.out_ready;
  // A pop in the same cycle frees the slot the push needs, so a full queue still takes beats.
  assign in_ready   = !queue_full || pop;
  assign accept     = in_ready && (is_valid || is_done);
  assign last_lane  = (idx == IDX_W'(NUM_LANES - 1));
  assign push       = accept && (is_done || last_lane);

  // Lanes at and above idx are always zero in the fill buffer, so the beat can be merged in place.
  always_comb begin
    word_next = (state == ST_EMPTY) ? '0 : fill_buf;
    mask_next = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (IDX_W'(l) == idx) word_next[l*DATA_W +: DATA_W] = bus.in_data;
      mask_next[l] = (IDX_W'(l) <= idx);
    end
  end

  assign count_next = CNT_W'(idx) + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_EMPTY;
      idx          <= '0;
      fill_buf     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      err_reserved <= 1'b0;
    end else begin
      if (accept) begin
        if (push) begin
          state    <= ST_EMPTY;
          idx      <= '0;
          fill_buf <= '0;
        end else begin
          state    <= ST_PARTIAL;
          idx      <= idx + 1'b1;
          fill_buf <= word_next;
        end
      end

      if (push) wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      if (is_reserved && in_ready) err_reserved <= 1'b1;
    end
  end

  // Queue storage needs no reset: entries are only observed through head_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr]  <= word_next;
      q_mask[wr_ptr]  <= mask_next;
      q_count[wr_ptr] <= count_next;
      q_last[wr_ptr]  <= is_done;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = head_valid;
  assign bus.out_data      = head_valid ? q_data[rd_ptr]  : '0;
  assign bus.out_lane_mask = head_valid ? q_mask[rd_ptr]  : '0;
  assign bus.out_count     = head_valid ? q_count[rd_ptr] : '0;
  assign bus.out_last      = head_valid && q_last[rd_ptr];
  assign bus.err_reserved  = err_reserved;

`ifdef HERO_GATHER_PARITY_EN
  logic [NUM_LANES-1:0] parity_next;
  logic [NUM_LANES-1:0] q_parity [OUT_DEPTH];

  always_comb begin
    parity_next = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      parity_next[l] = ^word_next[l*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_parity[wr_ptr] <= parity_next;
  end

  assign bus.out_parity = head_valid ? q_parity[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_hero_write_gather.sv
// Directed and randomized checks of hero_write_gather (DATA_W=8, NUM_LANES=4, OUT_DEPTH=2)
// against a queue-based model of the packing and output queue.
module tb_hero_write_gather;
  localparam int DW    = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    int          count;
    logic        last;
  } word_t;

  logic clk;
  logic rst_n;

  hero_write_gather_if #(.DATA_W(DW), .NUM_LANES(LANES)) bus ();

  hero_write_gather #(.DATA_W(DW), .NUM_LANES(LANES), .OUT_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  word_t      exp_q[$];
  logic [7:0] fill_q[$];
  logic       m_err;
  logic       last_in_ready;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] lane_parity(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < LANES; i++) p[i] = ^d[i*8 +: 8];
    return p;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic [1:0] t, input logic [7:0] d, input logic rdy);
    logic  head;
    logic  exp_ready;
    word_t w;
    bus.in_cycle_type = t;
    bus.in_data       = d;
    bus.out_ready     = rdy;
    #1;
    head      = (exp_q.size() > 0);
    exp_ready = (exp_q.size() < DEPTH) || (head && rdy);
    last_in_ready = bus.in_ready;
    chk("in_ready", bus.in_ready, exp_ready);
    chk("out_valid", bus.out_valid, head);
    if (head) begin
      chk("out_data", bus.out_data, exp_q[0].data);
      chk("out_lane_mask", bus.out_lane_mask, exp_q[0].mask);
      chk("out_count", bus.out_count, exp_q[0].count);
      chk("out_last", bus.out_last, exp_q[0].last);
`ifdef HERO_GATHER_PARITY_EN
      chk("out_parity", bus.out_parity, lane_parity(exp_q[0].data));
`endif
    end
    chk("err_reserved", bus.err_reserved, m_err);

    if (t == 2'd3 && exp_ready) m_err = 1'b1;
    if (head && rdy) void'(exp_q.pop_front());
    if (exp_ready && (t == 2'd1 || t == 2'd2)) begin
      fill_q.push_back(d);
      if (t == 2'd2 || fill_q.size() == LANES) begin
        w.data = '0;
        for (int i = 0; i < fill_q.size(); i++) w.data[i*8 +: 8] = fill_q[i];
        w.mask  = 4'((1 << fill_q.size()) - 1);
        w.count = fill_q.size();
        w.last  = (t == 2'd2);
        exp_q.push_back(w);
        fill_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.in_cycle_type = 2'd0;
    bus.in_data       = '0;
    bus.out_ready     = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    fill_q.delete();
    m_err = 1'b0;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_lane_mask", bus.out_lane_mask, 4'h0);
    chk("rst_out_count", bus.out_count, 3'd0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_err_reserved", bus.err_reserved, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef HERO_GATHER_PARITY_EN
    chk("rst_out_parity", bus.out_parity, 4'h0);
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    int accepted;
    int r;
    logic [1:0] t;
    rst_n             = 1'b0;
    m_err             = 1'b0;
    last_in_ready     = 1'b0;
    bus.in_cycle_type = 2'd0;
    bus.in_data       = '0;
    bus.out_ready     = 1'b0;
    do_reset();

    // Full word with the consumer ready.
    step(2'd1, 8'h11, 1'b1);
    step(2'd1, 8'h22, 1'b1);
    step(2'd1, 8'h33, 1'b1);
    step(2'd1, 8'h44, 1'b1);
    chk("full_data", bus.out_data, 32'h44332211);
    chk("full_mask", bus.out_lane_mask, 4'hF);
    chk("full_count", bus.out_count, 3'd4);
    chk("full_last", bus.out_last, 1'b0);
    step(2'd0, 8'h00, 1'b1);

    // Partial flush on DONE, then the next word restarts at lane 0.
    step(2'd1, 8'hAA, 1'b1);
    step(2'd2, 8'hBB, 1'b1);
    chk("flush_data", bus.out_data, 32'h0000BBAA);
    chk("flush_mask", bus.out_lane_mask, 4'h3);
    chk("flush_count", bus.out_count, 3'd2);
    chk("flush_last", bus.out_last, 1'b1);
    step(2'd2, 8'h5C, 1'b1);
    chk("single_done_data", bus.out_data, 32'h0000005C);
    chk("single_done_mask", bus.out_lane_mask, 4'h1);
    step(2'd0, 8'h00, 1'b1);

    // Backpressure: 12 VALID beats with the consumer stalled.
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      step(2'd1, 8'(8'h10 + i), 1'b0);
      if (last_in_ready) accepted++;
    end
    chk("bp_accepted", accepted, 8);
    chk("bp_head_held", bus.out_data, 32'h13121110);
    step(2'd0, 8'h00, 1'b1);
    chk("bp_ready_on_pop", last_in_ready, 1'b1);
    step(2'd0, 8'h00, 1'b1);
    step(2'd0, 8'h00, 1'b1);

    // Fill the queue, then push and pop in the same cycle.
    for (int i = 0; i < 8; i++) step(2'd1, 8'(8'h60 + i), 1'b0);
    step(2'd2, 8'hD0, 1'b1);
    chk("sim_in_ready", last_in_ready, 1'b1);
    step(2'd0, 8'h00, 1'b0);
    chk("sim_still_full", last_in_ready, 1'b0);
    for (int i = 0; i < 3; i++) step(2'd0, 8'h00, 1'b1);

    // Reset in the middle of a fill discards the partial word.
    step(2'd1, 8'hE1, 1'b1);
    step(2'd1, 8'hE2, 1'b1);
    do_reset();
    step(2'd1, 8'h01, 1'b1);
    step(2'd1, 8'h02, 1'b1);
    step(2'd1, 8'h03, 1'b1);
    step(2'd1, 8'h04, 1'b1);
    chk("rmid_data", bus.out_data, 32'h04030201);
    chk("rmid_mask", bus.out_lane_mask, 4'hF);
    chk("rmid_err", bus.err_reserved, 1'b0);
    step(2'd0, 8'h00, 1'b1);

    // Reserved cycle type writes no lane and sets the sticky error.
    step(2'd3, 8'hFF, 1'b1);
    chk("rsv_err_set", bus.err_reserved, 1'b1);
    step(2'd1, 8'h00, 1'b1);
    step(2'd1, 8'h01, 1'b1);
    step(2'd1, 8'h03, 1'b1);
    step(2'd1, 8'h07, 1'b1);
    chk("rsv_word", bus.out_data, 32'h07030100);
`ifdef HERO_GATHER_PARITY_EN
    chk("parity_word", bus.out_parity, 4'b1010);
`endif
    step(2'd0, 8'h00, 1'b1);
    chk("rsv_err_sticky", bus.err_reserved, 1'b1);

    // Randomized traffic with a varying consumer.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      t = 2'd1;
      else if (r < 8) t = 2'd2;
      else            t = 2'd0;
      step(t, 8'($urandom), ($urandom_range(0, 3) != 0) || (i >= 150 && i < 200 ? 1'b0 : 1'b0));
    end
    for (int i = 0; i < 100; i++) begin
      step(($urandom_range(0, 3) != 0) ? 2'd1 : 2'd2, 8'($urandom), ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 4; i++) step(2'd0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
